imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader: the write side of the core's read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into instruction memory through a single-cycle write port.
- Holds the pipelined core in reset while loading; releases it only after a complete, valid image.
- Sits between the host/debug byte source and the Instr_Mem write port, beside the core top.

Parameters:
- ADDR_W, 8, instruction memory word-address width; capacity = 2^ADDR_W words.
- BASE_ADDR, 0, first word address written; must be < 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse that begins a load.
- in_valid  in  1  byte source has data.
- in_data  in  8  byte from source.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  instruction word.
- core_rst_n  out  1  active-low reset to the core; 0 holds the core.
- busy  out  1  load in progress.
- done  out  1  last load completed OK; sticky until the next start or rst.
- error  out  1  last load failed; sticky until the next start or rst.
- words_loaded  out  ADDR_W+1  count of words written in the current/last load.

Behaviour:
- One clock; rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_rst_n=0, busy=0, done=0, error=0, words_loaded=0.
- Byte handshake: a byte transfers on a cycle where in_valid && in_ready. in_ready is a registered state decode and never depends on in_valid.
- FSM states and transitions:
  - IDLE: in_ready=0. start -> LEN_HI. Also: busy=1, core_rst_n=0, done=0, error=0, words_loaded=0, byte index=0, checksum accumulator=0.
  - LEN_HI: in_ready=1. The accepted byte becomes len[15:8]; go to LEN_LO.
  - LEN_LO: in_ready=1. The accepted byte becomes len[7:0].
    - If len==0: go to DONE (with CHECKSUM_EN, to CSUM).
    - If BASE_ADDR+len > 2^ADDR_W: go to ERROR.
    - Otherwise go to DATA.
  - DATA: in_ready=1. Accepted bytes shift into the word MSB first; the byte index counts 0..3.
    - On the 4th byte, the next cycle has imem_we=1, imem_wdata=assembled word, imem_addr=current address.
    - The address increments after the write; words_loaded increments with the write.
    - in_ready stays 1 during the write cycle. A byte accepted then belongs to the next word; no bubble.
    - After the write of word number len: go to DONE (with CHECKSUM_EN, to CSUM).
  - DONE: busy=0, done=1, core_rst_n=1, in_ready=0. start -> LEN_HI (core_rst_n drops to 0 the next cycle).
  - ERROR: busy=0, error=1, core_rst_n=0 (core stays held), in_ready=0. start -> LEN_HI.
- start while busy is ignored.
- Bytes presented while in_ready=0 are not consumed.
- rst mid-load: back to IDLE with all reset values. The partial word is discarded. No imem_we is issued in the cycle after rst.
- imem_addr wraps only by the overflow check. It never exceeds BASE_ADDR+len-1.
- The core must see core_rst_n=0 for at least the entire load. Release occurs only in the cycle DONE is entered, never earlier than the final imem_we.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit mod-256 sum accumulates over every accepted byte, including both length bytes.
  - After the last word (or directly after LEN_LO when len==0), state CSUM accepts one more byte.
  - If sum+byte == 8'h00 mod 256: go to DONE. Otherwise go to ERROR, with core_rst_n held at 0; words already written remain in memory.
- Undefined: no CSUM state and no accumulator logic. The last word write goes directly to DONE.

Test Plan:
- rst, start, stream 00 02 | 24 08 00 05 | 00 00 00 0C -> imem_we twice: addr 0 data 32'h24080005, addr 1 data 32'h0000000C; done=1, words_loaded=2, core_rst_n goes 1 the cycle after the 2nd write.
- in_valid held high continuously across a word boundary -> no bubble; 3 words = 14 bytes in 14 accepted cycles, 3 imem_we pulses exactly 4 cycles apart.
- ADDR_W=2, length 00 05 -> error=1 after LEN_LO, zero imem_we, core_rst_n stays 0; then start + valid 1-word image -> done=1.
- Assert rst after 6 data bytes of a 2-word load -> only word 0 written; all outputs at reset values the next cycle; restart loads correctly from BASE_ADDR.
- start pulses during DATA and length 00 00 -> mid-load start ignored; zero-length goes straight to done=1 with words_loaded=0.
- CHECKSUM_EN, image 00 01 | 00 00 00 01 with checksum FE -> done; same image with checksum FF -> error=1, core_rst_n=0.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader: boot-time byte-stream loader for the instruction memory.   |
// | Optional checksum byte: define IMEM_LOADER_CHECKSUM_EN.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
    S_DONE = 3'd4, S_ERROR = 3'd5, S_CSUM = 3'd6
  } state_t;
  localparam state_t c_after_load = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
    S_DONE = 3'd4, S_ERROR = 3'd5
  } state_t;
  localparam state_t c_after_load = S_DONE;
`endif

  localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       c_cap  = 32'(1) << ADDR_W;

  state_t            r_state, w_next;
  logic [15:0]       r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_words;
  logic [31:0]       r_word;
  logic [1:0]        r_idx;
  logic              r_we;
  logic              r_flush;   // final word is being written; no more data bytes
  logic              w_accept, w_idle, w_overflow, w_last_word, w_extra_ready;
  logic [15:0]       w_len_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_next;
  assign w_sum_next    = r_sum + in_data;
  assign w_extra_ready = (r_state == S_CSUM);
`else
  assign w_extra_ready = 1'b0;
`endif

  assign in_ready    = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                       ((r_state == S_DATA) && !r_flush) || w_extra_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
  assign w_len_full  = {r_len[15:8], in_data};
  assign w_overflow  = (32'(BASE_ADDR) + 32'(w_len_full)) > c_cap;
  assign w_last_word = (32'(r_words) + 32'd1) == 32'(r_len);

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_word;
  assign core_rst_n   = (r_state == S_DONE);
  assign busy         = !w_idle;
  assign done         = (r_state == S_DONE);
  assign error        = (r_state == S_ERROR);
  assign words_loaded = r_words;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_full == 16'd0) w_next = c_after_load;
          else if (w_overflow)     w_next = S_ERROR;
          else                     w_next = S_DATA;
        end
      end
      S_DATA: if (r_flush) w_next = c_after_load;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (w_accept) w_next = (w_sum_next == 8'h00) ? S_DONE : S_ERROR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len   <= 16'd0;
      r_addr  <= c_base;
      r_words <= '0;
      r_word  <= 32'd0;
      r_idx   <= 2'd0;
      r_we    <= 1'b0;
      r_flush <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum   <= 8'h00;
`endif
    end else begin
      r_we <= 1'b0;
      if (r_we) begin
        r_words <= r_words + (ADDR_W+1)'(1);
        // Holding the address on the last write keeps it inside the image.
        if (!r_flush) r_addr <= r_addr + ADDR_W'(1);
      end
      if ((r_state == S_DATA) && r_flush) r_flush <= 1'b0;
      if (w_idle && start) begin
        r_addr  <= c_base;
        r_words <= '0;
        r_idx   <= 2'd0;
        r_flush <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum   <= 8'h00;
`endif
      end
      if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum <= w_sum_next;
`endif
        case (r_state)
          S_LEN_HI: r_len[15:8] <= in_data;
          S_LEN_LO: r_len       <= w_len_full;
          S_DATA: begin
            r_word <= {r_word[23:0], in_data};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_we <= 1'b1;
              if (w_last_word) r_flush <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// Bench for imem_loader: image-level model with write scoreboard, plus literal checks.
module tb_imem_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, in_valid;
  logic [7:0] in_data;
  bit         sel;  // 0 drives the ADDR_W=8 instance, 1 the ADDR_W=2 instance

  logic rdy1, we1, rstn1, busy1, done1, err1;
  logic [7:0] addr1; logic [31:0] wd1; logic [8:0] wl1;
  logic rdy2, we2, rstn2, busy2, done2, err2;
  logic [1:0] addr2; logic [31:0] wd2; logic [2:0] wl2;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start && !sel), .in_valid(in_valid && !sel),
    .in_data(in_data), .in_ready(rdy1), .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wd1), .core_rst_n(rstn1), .busy(busy1), .done(done1),
    .error(err1), .words_loaded(wl1));

  imem_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start && sel), .in_valid(in_valid && sel),
    .in_data(in_data), .in_ready(rdy2), .imem_we(we2), .imem_addr(addr2),
    .imem_wdata(wd2), .core_rst_n(rstn2), .busy(busy2), .done(done2),
    .error(err2), .words_loaded(wl2));

  logic        rdy_s, we_s, rstn_s, busy_s, done_s, err_s;
  logic [31:0] addr_s, wd_s, wl_s;
  assign rdy_s  = sel ? rdy2  : rdy1;
  assign we_s   = sel ? we2   : we1;
  assign rstn_s = sel ? rstn2 : rstn1;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;
  assign err_s  = sel ? err2  : err1;
  assign addr_s = sel ? 32'(addr2) : 32'(addr1);
  assign wd_s   = sel ? wd2 : wd1;
  assign wl_s   = sel ? 32'(wl2) : 32'(wl1);

  int tests = 0, fails = 0;
  int cyc = 0, last_we_cyc = 0, rise_cyc = 0, we_count = 0;
  int we_cycs[$], acc_cycs[$];
  logic prev_rstn = 1'b0;
  logic [31:0] exp_addr[$], exp_data[$];
  logic [31:0] mem [0:255];
  logic [7:0]  img[$];
  bit exp_done;
  int exp_words, n_consume;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle scoreboard, sampled 1 time unit after the falling edge.
  always begin
    @(negedge clk); #1;
    cyc++;
    if (we_s) begin
      we_count++;
      we_cycs.push_back(cyc);
      last_we_cyc = cyc;
      mem[addr_s[7:0]] = wd_s;
      chk("write_expected", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) begin
        chk("write_addr", addr_s, exp_addr.pop_front());
        chk("write_data", wd_s, exp_data.pop_front());
      end
    end
    if (busy_s) chk("core_held_while_busy", 32'(rstn_s), 32'd0);
    if (rstn_s && !prev_rstn) rise_cyc = cyc;
    prev_rstn = rstn_s;
    if (in_valid && rdy_s) acc_cycs.push_back(cyc);
  end

  // Expected outcome of loading img, from the image format alone.
  task automatic model();
    int len, cap;
    logic [7:0] s;
    len = {img[0], img[1]};
    cap = sel ? 4 : 256;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b1; exp_words = 0; n_consume = 2;
    if (len > cap) exp_done = 1'b0;
    else begin
      exp_words = len;
      n_consume = 2 + 4 * len;
      for (int w = 0; w < len; w++) begin
        exp_addr.push_back(32'(w));
        exp_data.push_back({img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]});
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      n_consume++;
      s = 8'h00;
      for (int i = 0; i < n_consume; i++) s = s + img[i];
      exp_done = (s == 8'h00);
`endif
    end
  endtask

  task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] s;
    s = 8'h00;
    foreach (img[i]) s = s + img[i];
    img.push_back(8'h00 - s);
`endif
  endtask

  task automatic run_load(input int stop_after, input int start_at);
    int t, lim;
    model();
    we_count = 0; we_cycs.delete(); acc_cycs.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lim = (stop_after >= 0) ? stop_after : n_consume;
    for (int i = 0; i < lim; i++) begin
      in_valid = 1'b1; in_data = img[i]; start = (i == start_at);
      t = 0;
      while (!rdy_s && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        chk("in_ready_timeout", 32'(t), 32'd0);
        in_valid = 1'b0; start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    if (stop_after >= 0) return;
    t = 0;
    while (busy_s && t < 100) begin @(negedge clk); t++; end
    chk("busy_timeout", 32'(t < 100), 32'd1);
    @(negedge clk); #2;
    chk("done", 32'(done_s), 32'(exp_done));
    chk("error", 32'(err_s), 32'(!exp_done));
    chk("core_rst_n", 32'(rstn_s), 32'(exp_done));
    chk("words_loaded", wl_s, 32'(exp_words));
    chk("write_count", 32'(we_count), 32'(exp_words));
    chk("writes_pending", 32'(exp_addr.size()), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (exp_done && exp_words > 0) chk("release_after_last_write", 32'(rise_cyc - last_we_cyc), 32'd1);
`endif
  endtask

  task automatic check_reset();
    chk("rst_in_ready", 32'(rdy1), 32'd0);
    chk("rst_imem_we", 32'(we1), 32'd0);
    chk("rst_imem_addr", 32'(addr1), 32'd0);
    chk("rst_imem_wdata", wd1, 32'd0);
    chk("rst_core_rst_n", 32'(rstn1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_error", 32'(err1), 32'd0);
    chk("rst_words_loaded", 32'(wl1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2 check_reset();

    // Two-word image, pinned against literal words.
    img = {8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    add_csum();
    run_load(-1, -1);
    chk("lit_mem0", mem[0], 32'h24080005);
    chk("lit_mem1", mem[1], 32'h0000000C);
    chk("lit_words", wl_s, 32'd2);

    // Three words with in_valid held high: no bubble across word boundaries.
    img = {8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67,
           8'h89, 8'hAB, 8'hCD, 8'hEF};
    add_csum();
    run_load(-1, -1);
    chk("acc_total", 32'(acc_cycs.size()), 32'(n_consume));
    if (acc_cycs.size() >= 14) chk("acc_span_14", 32'(acc_cycs[13] - acc_cycs[0]), 32'd13);
    if (we_cycs.size() == 3) begin
      chk("we_gap_01", 32'(we_cycs[1] - we_cycs[0]), 32'd4);
      chk("we_gap_12", 32'(we_cycs[2] - we_cycs[1]), 32'd4);
    end else chk("we_pulses", 32'(we_cycs.size()), 32'd3);
    chk("lit_mem2", mem[2], 32'h89ABCDEF);

    // Small memory: oversize length is rejected, then a fitting image loads.
    sel = 1'b1;
    img = {8'h00, 8'h05};
    run_load(-1, -1);
    chk("lit_overflow_err", 32'(err2), 32'd1);
    img = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    add_csum();
    run_load(-1, -1);
    chk("lit_small_mem0", mem[0], 32'hCAFEF00D);
    sel = 1'b0;

    // Reset after six data bytes of a two-word load.
    img = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    add_csum();
    run_load(8, -1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #2 check_reset();
    chk("partial_write_count", 32'(we_count), 32'd1);
    chk("lit_partial_mem0", mem[0], 32'h11223344);
    exp_addr.delete(); exp_data.delete();
    run_load(-1, -1);
    chk("lit_restart_mem1", mem[1], 32'h55667788);

    // start pulse mid-load is ignored; then a zero-length image.
    img = {8'h00, 8'h02, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    add_csum();
    run_load(-1, 5);
    chk("lit_midstart_mem1", mem[1], 32'hB0B1B2B3);
    img = {8'h00, 8'h00};
    add_csum();
    run_load(-1, -1);
    chk("lit_zero_len_done", 32'(done1), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFE};
    run_load(-1, -1);
    chk("lit_csum_ok", 32'(done1), 32'd1);
    img = {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF};
    run_load(-1, -1);
    chk("lit_csum_bad_err", 32'(err1), 32'd1);
    chk("lit_csum_bad_rstn", 32'(rstn1), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
